mem_responder: RTL

Multicycle memory responder on the memory side of the control FSM's memory request port. Accepts one word read or write request at a time over a valid/ready handshake and holds it for a programmable number of wait cycles. Commits the access to an internal word array and returns a single-cycle response pulse with read data. Replaces the zero-latency memory model, so the control FSM and the datapath can be exercised against realistic memory wait states.

---
 rtl/mem_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Multicycle word memory responder: one request at a time, LATENCY wait states, one-cycle response pulse.
// Optional misaligned-address rejection is enabled by defining MEM_RESP_ALIGN_CHECK_EN.
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);
    localparam int         Depth        = 1 << ADDR_WIDTH;
    localparam logic [3:0] LatencyCount = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    misalign_q, misalign_d;
    logic                    req_ready_q, resp_valid_q, busy_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;

    logic [DATA_WIDTH-1:0]   mem [Depth];

    logic                    accept;
    logic                    commit;
    logic                    commitWe;
    logic [ADDR_WIDTH-1:0]   commitIdx;
    logic [DATA_WIDTH-1:0]   commitWdata;
    logic                    commitMisalign;
    logic                    commitErr;
    logic                    memWrite;
    logic                    unusedBits;

    assign accept = req_valid && req_ready_q;

    // With zero latency the commit uses the live request inputs on the acceptance edge itself.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        we_d           = we_q;
        idx_d          = idx_q;
        wdata_d        = wdata_q;
        misalign_d     = misalign_q;
        commit         = 1'b0;
        commitWe       = we_q;
        commitIdx      = idx_q;
        commitWdata    = wdata_q;
        commitMisalign = misalign_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d       = req_we;
                    idx_d      = req_addr[ADDR_WIDTH+1:2];
                    wdata_d    = req_wdata;
                    misalign_d = (req_addr[1:0] != 2'b00);
                    cnt_d      = LatencyCount;
                    if (LATENCY == 0) begin
                        commit         = 1'b1;
                        commitWe       = req_we;
                        commitIdx      = req_addr[ADDR_WIDTH+1:2];
                        commitWdata    = req_wdata;
                        commitMisalign = (req_addr[1:0] != 2'b00);
                        state_d        = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign commitErr  = commitMisalign;
    assign unusedBits = ^req_addr[31:ADDR_WIDTH+2];
`else
    assign commitErr  = 1'b0;
    assign unusedBits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0], commitMisalign};
`endif

    assign memWrite     = commit && commitWe && !commitErr;
    assign resp_rdata_d = (commit && !commitWe && !commitErr) ? mem[commitIdx] : '0;
    assign resp_err_d   = commit && commitErr;

    // Output registers follow the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            misalign_q   <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            misalign_q   <= misalign_d;
            req_ready_q  <= (state_d == IDLE);
            resp_valid_q <= (state_d == RESP);
            busy_q       <= (state_d != IDLE);
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage is deliberately not reset so it can map onto a RAM.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            mem[commitIdx] <= commitWdata;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule
